// File: rtl/pair_ser_pkg.sv
// Shared types for the pair nibble serializer.
// Pair word layout, nibble type and emit phase.
package pair_ser_pkg;

   localparam int NIB_W = 4;

   typedef logic [NIB_W-1:0] nibble_t;

   typedef struct packed {
      nibble_t hi;
      nibble_t lo;
   } pair_t;

   typedef enum logic {
      PH_LO = 1'b0,
      PH_HI = 1'b1
   } phase_e;

endpackage

// File: rtl/pair_ser_fifo.sv
// Small synchronous FIFO for packed pair words.
// Head is read combinationally from registered storage.
module pair_ser_fifo
   import pair_ser_pkg::*;
#(
   parameter int  DEPTH  = 2,
   parameter type data_t = pair_t
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  data_t                  din,
   output logic                   full,
   output logic                   empty,
   output data_t                  head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   data_t         mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          wr_en;
   logic          rd_en;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign wr_en = push && !full;
   assign rd_en = pop && !empty;
   assign head  = mem[rd_ptr];

   // Storage write at the tail; contents need no reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pair_nibble_serializer.sv
// Re-emits buffered pair words as lo then hi nibble beats.
// Optional parity output enabled by PAIR_SER_PARITY_EN.
module pair_nibble_serializer
   import pair_ser_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [NIB_W-1:0] out_data,
   output logic             out_last,
   output logic [CNT_W-1:0] word_cnt,
   output logic             busy
`ifdef PAIR_SER_PARITY_EN
   ,
   output logic             out_par
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   phase_e        phase;
   pair_t         head;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          beat;

   assign in_ready  = !full;
   assign push      = in_valid && in_ready;
   assign out_valid = !empty;
   assign beat      = out_valid && out_ready;
   assign pop       = beat && (phase == PH_HI);
   assign busy      = (count != '0);

   pair_ser_fifo #(
      .DEPTH  (DEPTH),
      .data_t (pair_t)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (pair_t'(in_data)),
      .full  (full),
      .empty (empty),
      .head  (head),
      .count (count)
   );

   // Phase advances on every accepted beat; pops happen on the hi beat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase <= PH_LO;
      end else if (beat) begin
         phase <= (phase == PH_LO) ? PH_HI : PH_LO;
      end
   end

   // Count completed words, sticking at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word_cnt <= '0;
      end else if (pop && (word_cnt != '1)) begin
         word_cnt <= word_cnt + CNT_W'(1);
      end
   end

   // Select the current nibble; idle outputs are forced to zero.
   always_comb begin
      out_data = '0;
      out_last = 1'b0;
      if (!empty) begin
         out_data = (phase == PH_HI) ? head.hi : head.lo;
         out_last = (phase == PH_HI);
      end
   end

`ifdef PAIR_SER_PARITY_EN
   assign out_par = ^out_data;
`endif

endmodule

// File: tb/tb_pair_nibble_serializer.sv
// Directed bench for pair_nibble_serializer.
// Uses DEPTH=2 and a 3-bit counter so saturation is reachable.
module tb_pair_nibble_serializer;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic       out_last;
   logic [2:0] word_cnt;
   logic       busy;
`ifdef PAIR_SER_PARITY_EN
   logic       out_par;
`endif

   int checks;
   int errors;

   pair_nibble_serializer #(
      .DEPTH (2),
      .CNT_W (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .word_cnt  (word_cnt),
      .busy      (busy)
`ifdef PAIR_SER_PARITY_EN
      ,
      .out_par   (out_par)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_beat(input string tag, input logic [3:0] d,
                           input logic l);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"}, 32'(out_data), 32'(d));
      chk({tag, "_last"}, 32'(out_last), 32'(l));
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // reset / idle
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_cnt", 32'(word_cnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_last", 32'(out_last), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);

      // single word 0xA5
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hA5;
      tick();
      in_valid = 1'b0;
      chk_beat("a5_lo", 4'h5, 1'b0);
      chk("a5_busy", 32'(busy), 32'd1);
      tick();
      chk_beat("a5_hi", 4'hA, 1'b1);
      tick();
      chk("a5_done_valid", 32'(out_valid), 32'd0);
      chk("a5_cnt", 32'(word_cnt), 32'd1);
      chk("a5_busy_end", 32'(busy), 32'd0);

      // back-to-back fill with backpressure
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h12;
      tick();
      chk("fill1_ready", 32'(in_ready), 32'd1);
      in_data = 8'h34;
      tick();
      chk("fill2_ready", 32'(in_ready), 32'd0);
      in_data = 8'h56;
      tick();
      chk("fill3_ready", 32'(in_ready), 32'd0);
      chk_beat("w12_lo_hold", 4'h2, 1'b0);
      out_ready = 1'b1;
      tick();
      chk_beat("w12_hi", 4'h1, 1'b1);
      chk("w12_hi_ready", 32'(in_ready), 32'd0);
      tick();
      chk_beat("w34_lo", 4'h4, 1'b0);
      chk("w34_lo_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk_beat("w34_hi", 4'h3, 1'b1);
      tick();
      chk_beat("w56_lo", 4'h6, 1'b0);
      tick();
      chk_beat("w56_hi", 4'h5, 1'b1);
      tick();
      chk("fill_done_valid", 32'(out_valid), 32'd0);
      chk("fill_cnt", 32'(word_cnt), 32'd4);

      // stall on the hi beat
      in_valid = 1'b1;
      in_data  = 8'hA5;
      tick();
      in_valid = 1'b0;
      chk_beat("st_lo", 4'h5, 1'b0);
      tick();
      out_ready = 1'b0;
      chk_beat("st_hi", 4'hA, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_beat("st_hold", 4'hA, 1'b1);
         chk("st_hold_cnt", 32'(word_cnt), 32'd4);
      end
      out_ready = 1'b1;
      tick();
      chk("st_rel_valid", 32'(out_valid), 32'd0);
      chk("st_rel_cnt", 32'(word_cnt), 32'd5);
      tick();
      chk("st_rel_cnt2", 32'(word_cnt), 32'd5);

`ifdef PAIR_SER_PARITY_EN
      // parity on both beats
      chk("par_idle", 32'(out_par), 32'd0);
      in_valid = 1'b1;
      in_data  = 8'h71;
      tick();
      in_data = 8'h33;
      chk_beat("p71_lo", 4'h1, 1'b0);
      chk("p71_lo_par", 32'(out_par), 32'd1);
      tick();
      in_valid = 1'b0;
      chk_beat("p71_hi", 4'h7, 1'b1);
      chk("p71_hi_par", 32'(out_par), 32'd1);
      tick();
      chk_beat("p33_lo", 4'h3, 1'b0);
      chk("p33_lo_par", 32'(out_par), 32'd0);
      tick();
      chk_beat("p33_hi", 4'h3, 1'b1);
      chk("p33_hi_par", 32'(out_par), 32'd0);
      tick();
      chk("par_end", 32'(out_par), 32'd0);
      chk("par_cnt", 32'(word_cnt), 32'd7);
`endif

      // reset between lo and hi beats of 0xC3
      in_valid = 1'b1;
      in_data  = 8'hC3;
      tick();
      in_valid = 1'b0;
      chk_beat("c3_lo", 4'h3, 1'b0);
      tick();
      chk_beat("c3_hi", 4'hC, 1'b1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mrst_valid", 32'(out_valid), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_cnt", 32'(word_cnt), 32'd0);
      chk("mrst_last", 32'(out_last), 32'd0);
      chk("mrst_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mrst_quiet", 32'(out_valid), 32'd0);
         chk("mrst_quiet_data", 32'(out_data), 32'd0);
      end

      // counter saturation at 3'b111
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h10 * (i + 1) + i);
         tick();
         in_valid = 1'b0;
         tick();
         tick();
         chk("sat_cnt", 32'(word_cnt), (i < 7) ? 32'(i + 1) : 32'd7);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
